// File: rtl/gpu_pkg.sv
// Shared definitions for the cube renderer: vertex fixed-point format, the
// 12-entry cube triangle table with face colours, and the sequencer states.
package gpu_pkg;

  localparam int FRAC_BITS = 8;
  localparam int NUM_TRIS  = 12;
  localparam logic [3:0] LAST_IDX = 4'(NUM_TRIS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_DECIDE,
    ST_DRAW,
    ST_RELEASE,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  // Element [0] is v1, [1] is v2, [2] is v3.
  function automatic logic [2:0][2:0] vi3(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
    return {c, b, a};
  endfunction

  // Vertex order 0 btl, 1 btr, 2 bbl, 3 bbr, 4 ftl, 5 ftr, 6 fbl, 7 fbr;
  // every entry is wound so that a visible face has positive signed area.
  function automatic logic [2:0][2:0] tri_vidx(input logic [3:0] idx);
    case (idx)
      4'd0:    return vi3(3'd4, 3'd5, 3'd0);
      4'd1:    return vi3(3'd0, 3'd5, 3'd1);
      4'd2:    return vi3(3'd6, 3'd2, 3'd7);
      4'd3:    return vi3(3'd7, 3'd2, 3'd3);
      4'd4:    return vi3(3'd6, 3'd7, 3'd4);
      4'd5:    return vi3(3'd4, 3'd7, 3'd5);
      4'd6:    return vi3(3'd3, 3'd2, 3'd1);
      4'd7:    return vi3(3'd1, 3'd2, 3'd0);
      4'd8:    return vi3(3'd2, 3'd6, 3'd0);
      4'd9:    return vi3(3'd0, 3'd6, 3'd4);
      4'd10:   return vi3(3'd7, 3'd3, 3'd5);
      4'd11:   return vi3(3'd5, 3'd3, 3'd1);
      default: return vi3(3'd0, 3'd0, 3'd0);
    endcase
  endfunction

  // Colour element [0] is red, [1] green, [2] blue.
  function automatic logic [2:0][7:0] rgb8(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {b, g, r};
  endfunction

  // Two consecutive triangles share a face, so the face is idx/2.
  function automatic logic [2:0][7:0] face_rgb(input logic [3:0] idx);
    case (idx[3:1])
      3'd0:    return rgb8(8'd255, 8'd255, 8'd0);
      3'd1:    return rgb8(8'd0,   8'd255, 8'd255);
      3'd2:    return rgb8(8'd255, 8'd0,   8'd0);
      3'd3:    return rgb8(8'd0,   8'd255, 8'd0);
      3'd4:    return rgb8(8'd0,   8'd0,   8'd255);
      3'd5:    return rgb8(8'd255, 8'd0,   8'd255);
      default: return rgb8(8'd0,   8'd0,   8'd0);
    endcase
  endfunction

endpackage

// File: rtl/tri_signed_area.sv
// Twice the signed area of a 2D triangle; positive for the winding the cube
// table uses for front-facing triangles. Also intended for edge setup.
module tri_signed_area (
  input  logic signed [31:0] x1,
  input  logic signed [31:0] y1,
  input  logic signed [31:0] x2,
  input  logic signed [31:0] y2,
  input  logic signed [31:0] x3,
  input  logic signed [31:0] y3,
  output logic signed [63:0] area
);

  logic signed [32:0] dx21, dy21, dx31, dy31;
  logic signed [63:0] ex21, ey21, ex31, ey31;

  assign dx21 = {x2[31], x2} - {x1[31], x1};
  assign dy21 = {y2[31], y2} - {y1[31], y1};
  assign dx31 = {x3[31], x3} - {x1[31], x1};
  assign dy31 = {y3[31], y3} - {y1[31], y1};

  // With |coord| < 2^30 each product stays below 2^62, so 64 bits cannot overflow.
  assign ex21 = {{31{dx21[32]}}, dx21};
  assign ey21 = {{31{dy21[32]}}, dy21};
  assign ex31 = {{31{dx31[32]}}, dx31};
  assign ey31 = {{31{dy31[32]}}, dy31};

  assign area = ex31 * ey21 - ex21 * ey31;

endmodule

// File: rtl/cube_tri_sequencer.sv
// Walks the 12 cube triangles through the single-triangle rasterizer, using a
// snapshot of the projected vertices and optional back-face/degenerate culling.
module cube_tri_sequencer
  import gpu_pkg::*;
#(
  parameter int FRAC_BITS = gpu_pkg::FRAC_BITS,
  parameter bit CULL_EN   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [7:0][2:0][31:0] verts,
  output logic [2:0][31:0]      tri_v1,
  output logic [2:0][31:0]      tri_v2,
  output logic [2:0][31:0]      tri_v3,
  output logic [2:0][7:0]       tri_rgb,
  output logic                  tri_start,
  input  logic                  tri_done,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            tri_count,
  output seq_state_t            dbg_state
);

  if (FRAC_BITS < 0 || FRAC_BITS > 30) begin : g_frac_check
    $error("cube_tri_sequencer: FRAC_BITS must lie in 0..30");
  end

  seq_state_t            state;
  logic [3:0]            idx;
  logic [7:0][2:0][31:0] snap;
  logic [2:0][2:0]       vsel;
  logic [2:0][31:0]      p1, p2, p3;
  logic signed [63:0]    area;
  logic signed [63:0]    area_q;

  assign vsel      = tri_vidx(idx);
  assign p1        = snap[vsel[0]];
  assign p2        = snap[vsel[1]];
  assign p3        = snap[vsel[2]];
  assign dbg_state = state;

  tri_signed_area u_area (
    .x1   (p1[0]),
    .y1   (p1[1]),
    .x2   (p2[0]),
    .y2   (p2[1]),
    .x3   (p3[0]),
    .y3   (p3[1]),
    .area (area)
  );

  // Rasterizer handshake is four-phase on levels: tri_start rises with the
  // triangle already stable, tri_done rises when drawing finishes, tri_start
  // falls, and the next triangle waits until tri_done has fallen too.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      idx       <= '0;
      tri_count <= '0;
      tri_start <= 1'b0;
      tri_v1    <= '0;
      tri_v2    <= '0;
      tri_v3    <= '0;
      tri_rgb   <= '0;
      area_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LATCH;
            busy  <= 1'b1;
          end
        end
        ST_LATCH: begin
          snap      <= verts;
          idx       <= '0;
          tri_count <= '0;
          state     <= ST_SETUP;
        end
        ST_SETUP: begin
          tri_v1  <= p1;
          tri_v2  <= p2;
          tri_v3  <= p3;
          tri_rgb <= face_rgb(idx);
          area_q  <= area;
          state   <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (CULL_EN && area_q <= 64'sd0) begin
            state <= ST_NEXT;
          end else begin
            tri_start <= 1'b1;
            tri_count <= tri_count + 4'd1;
            state     <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (tri_done) begin
            tri_start <= 1'b0;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!tri_done) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 4'd1;
            state <= ST_SETUP;
          end
        end
        ST_DONE: begin
          // A held start must drop before another pass can begin.
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_tri_sequencer.sv
// Bench for cube_tri_sequencer: one culling and one non-culling instance, a
// rasterizer responder, and a triangle-list model built from the cube table.
module tb_cube_tri_sequencer;
  import gpu_pkg::*;

  localparam int TW = 312;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET;

  logic [1:0]            start;
  logic [1:0]            tri_done;
  logic [7:0][2:0][31:0] verts;
  wire  [1:0]            tri_start, busy, done;
  wire  [2:0][31:0]      tv1 [2];
  wire  [2:0][31:0]      tv2 [2];
  wire  [2:0][31:0]      tv3 [2];
  wire  [2:0][7:0]       trgb [2];
  wire  [3:0]            tcount [2];
  wire  [2:0]            dstate [2];

  cube_tri_sequencer #(.FRAC_BITS(8), .CULL_EN(1'b0)) u_all (
    .CLK(CLK), .RESET(RESET), .start(start[0]), .verts(verts),
    .tri_v1(tv1[0]), .tri_v2(tv2[0]), .tri_v3(tv3[0]), .tri_rgb(trgb[0]),
    .tri_start(tri_start[0]), .tri_done(tri_done[0]), .busy(busy[0]),
    .done(done[0]), .tri_count(tcount[0]), .dbg_state(dstate[0])
  );

  cube_tri_sequencer #(.FRAC_BITS(8), .CULL_EN(1'b1)) u_cull (
    .CLK(CLK), .RESET(RESET), .start(start[1]), .verts(verts),
    .tri_v1(tv1[1]), .tri_v2(tv2[1]), .tri_v3(tv3[1]), .tri_rgb(trgb[1]),
    .tri_start(tri_start[1]), .tri_done(tri_done[1]), .busy(busy[1]),
    .done(done[1]), .tri_count(tcount[1]), .dbg_state(dstate[1])
  );

  // model state and scoreboard
  int tbl [12][3] = '{'{4,5,0}, '{0,5,1}, '{6,2,7}, '{7,2,3}, '{6,7,4}, '{4,7,5},
                      '{3,2,1}, '{1,2,0}, '{2,6,0}, '{0,6,4}, '{7,3,5}, '{5,3,1}};
  int rgbt [6][3] = '{'{255,255,0}, '{0,255,255}, '{255,0,0}, '{0,255,0},
                      '{0,0,255}, '{255,0,255}};
  int bv [8][3];
  logic [TW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  pass_drawn = 0;
  bit  pass_active [2];
  bit  rast_rand = 1'b0;

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_int(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic longint area_of(input longint x1, input longint y1, input longint x2,
                                     input longint y2, input longint x3, input longint y3);
    return (x3 - x1) * (y2 - y1) - (x2 - x1) * (y3 - y1);
  endfunction

  // Triangles the pass must draw, in table order, given the current bv.
  task automatic build_expected(input bit cull, input bit push, output int n);
    int a, b, c, f;
    longint ar;
    n = 0;
    for (int t = 0; t < 12; t++) begin
      a = tbl[t][0]; b = tbl[t][1]; c = tbl[t][2]; f = t / 2;
      ar = area_of(bv[a][0], bv[a][1], bv[b][0], bv[b][1], bv[c][0], bv[c][1]);
      if (!cull || ar > 0) begin
        n++;
        if (push)
          exp_q.push_back({8'(rgbt[f][2]), 8'(rgbt[f][1]), 8'(rgbt[f][0]),
                           32'(bv[c][2]), 32'(bv[c][1]), 32'(bv[c][0]),
                           32'(bv[b][2]), 32'(bv[b][1]), 32'(bv[b][0]),
                           32'(bv[a][2]), 32'(bv[a][1]), 32'(bv[a][0])});
      end
    end
  endtask

  task automatic pack_verts();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++) verts[i][k] = 32'(bv[i][k]);
  endtask

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < 8; i++) begin
      bv[i][0] = x; bv[i][1] = y; bv[i][2] = 0;
    end
  endtask

  task automatic rand_verts();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++) bv[i][k] = int'($urandom_range(0, 2097152)) - 1048576;
  endtask

  // rasterizer responder: tri_done rises some cycles after tri_start and
  // falls once tri_start has dropped; idle instances see random tri_done noise
  int rcnt [2];
  int rdly [2];
  initial begin
    tri_done = '0;
    rcnt = '{0, 0};
    rdly = '{5, 5};
    forever begin
      @(negedge CLK);
      for (int g = 0; g < 2; g++) begin
        if (RESET || !tri_start[g]) begin
          rcnt[g] = 0;
          tri_done[g] = (!pass_active[g] && !RESET) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
          if (rcnt[g] == 0) rdly[g] = rast_rand ? int'($urandom_range(1, 8)) : 5;
          rcnt[g]++;
          if (rcnt[g] >= rdly[g]) tri_done[g] = 1'b1;
        end
      end
    end
  end

  // compare process: every triangle handed over must be the next expected one
  // and must stay stable while tri_start is high
  logic          prev_ts [2];
  logic [TW-1:0] held [2];
  initial begin
    logic [TW-1:0] got;
    prev_ts = '{1'b0, 1'b0};
    forever begin
      @(negedge CLK);
      for (int g = 0; g < 2; g++) begin
        if (RESET) begin
          prev_ts[g] = 1'b0;
        end else begin
          got = {trgb[g], tv3[g], tv2[g], tv1[g]};
          if (tri_start[g] && !prev_ts[g]) begin
            pass_drawn++;
            chk_int("tri_count_inc", tcount[g], pass_drawn);
            if (exp_q.size() == 0) chk_int("tri_unexpected", 1, 0);
            else chk("tri_data", got, exp_q.pop_front());
            held[g] = got;
          end else if (tri_start[g]) begin
            chk("tri_hold", got, held[g]);
          end
          chk_int("done_busy_excl", {done[g], busy[g]} == 2'b11, 0);
          prev_ts[g] = tri_start[g];
        end
      end
    end
  end

  // driver: one full pass on instance g
  task automatic run_pass(input int g, input bit scramble, input int hold,
                          output int first_ts, output int done_at);
    int n_exp, n;
    pack_verts();
    build_expected(g == 1, 1'b1, n_exp);
    pass_drawn = 0;
    pass_active[g] = 1'b1;
    first_ts = -1;
    done_at = -1;
    n = 0;
    @(negedge CLK);
    start[g] = 1'b1;
    while (n < 4000 && done_at < 0) begin
      @(negedge CLK);
      n++;
      if (tri_start[g] && first_ts < 0) first_ts = n;
      if (scramble && n >= 2 && tri_start[g])
        verts[$urandom_range(0, 7)][$urandom_range(0, 2)] = $urandom();
      if (done[g]) done_at = n;
    end
    if (done_at < 0) begin
      chk_int("done_timeout", 0, 1);
      RESET = 1'b1;
      start[g] = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      exp_q.delete();
      pass_active[g] = 1'b0;
      return;
    end
    chk_int("pass_tri_count", tcount[g], n_exp);
    chk_int("pass_queue_empty", exp_q.size(), 0);
    chk_int("pass_busy_low", busy[g], 0);
    chk_int("pass_state_done", dstate[g], 3'(ST_DONE));
    repeat (hold) begin
      @(negedge CLK);
      chk_int("done_held", {done[g], tri_start[g], busy[g], dstate[g] == 3'(ST_DONE)}, 4'b1001);
    end
    start[g] = 1'b0;
    @(negedge CLK);
    chk_int("done_clear", done[g], 0);
    chk_int("back_to_idle", dstate[g], 3'(ST_IDLE));
    pass_active[g] = 1'b0;
    pack_verts();
  endtask

  task automatic reset_mid_draw();
    int n_exp, k;
    pack_verts();
    build_expected(1'b0, 1'b1, n_exp);
    pass_drawn = 0;
    pass_active[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b1;
    k = 0;
    while (!tri_start[0] && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk_int("reset_reach_draw", tri_start[0], 1);
    @(negedge CLK);
    RESET = 1'b1;
    start[0] = 1'b0;
    @(negedge CLK);
    chk_int("rst_tri_start", tri_start[0], 0);
    chk_int("rst_busy", busy[0], 0);
    chk_int("rst_tri_count", tcount[0], 0);
    chk_int("rst_state", dstate[0], 3'(ST_IDLE));
    chk_int("rst_done", done[0], 0);
    RESET = 1'b0;
    exp_q.delete();
    pass_active[0] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, fts, dat, g;
    RESET = 1'b1;
    start = '0;
    pass_active = '{1'b0, 1'b0};
    set_all(150 << 8, 150 << 8);
    pack_verts();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk_int("reset_outputs", {tri_start[i], busy[i], done[i], tcount[i]}, 0);
      chk_int("reset_state", dstate[i], 3'(ST_IDLE));
      chk("reset_tri", {trgb[i], tv3[i], tv2[i], tv1[i]}, '0);
    end
    RESET = 1'b0;
    @(negedge CLK);

    // all vertices coincide: everything culled, or all 12 drawn without culling
    set_all(150 << 8, 150 << 8);
    build_expected(1'b1, 1'b0, n);
    chk_int("model_all_culled", n, 0);
    build_expected(1'b0, 1'b0, n);
    chk_int("model_all_drawn", n, 12);
    run_pass(1, 1'b0, 0, fts, dat);
    chk_int("culled_no_tri_start", fts, -1);
    chk_int("culled_done_latency", dat, 38);
    run_pass(0, 1'b0, 20, fts, dat);
    chk_int("first_tri_start_latency", fts, 4);

    // only the front face is visible
    set_all(150 << 8, 150 << 8);
    bv[4][0] = 100 << 8; bv[4][1] = 100 << 8;
    bv[5][0] = 200 << 8; bv[5][1] = 100 << 8;
    bv[6][0] = 100 << 8; bv[6][1] = 200 << 8;
    bv[7][0] = 200 << 8; bv[7][1] = 200 << 8;
    chk_int("model_front_area", area_of(bv[6][0], bv[6][1], bv[7][0], bv[7][1],
                                        bv[4][0], bv[4][1]), 64'd655360000);
    build_expected(1'b1, 1'b0, n);
    chk_int("model_front_count", n, 2);
    run_pass(1, 1'b0, 1, fts, dat);
    run_pass(1, 1'b1, 0, fts, dat);

    // reset in the middle of a draw, then a clean pass from idx 0
    set_all(150 << 8, 150 << 8);
    reset_mid_draw();
    run_pass(0, 1'b0, 0, fts, dat);

    // randomized vertices, rasterizer latency and start hold
    rast_rand = 1'b1;
    repeat (16) begin
      rand_verts();
      g = int'($urandom_range(0, 1));
      run_pass(g, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 3)), fts, dat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
